// File: rtl/lsu_ctrl.sv
// Load/store control unit: one request per handshake, address/alignment/range checks, one-cycle memory access, extended load response.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned effective addresses into exception 01 instead of letting them reach memory.
module lsu_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [63:0]       req_base,
    input  logic [11:0]       req_imm,
    input  logic [63:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic [1:0]        resp_exc,
    output logic [63:0]       resp_badaddr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_dataw,
    output logic [1:0]        mem_word,
    output logic              mem_rw,
    input  logic [63:0]       mem_datar
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_nxt;

    logic signed [63:0] imm_sx_p0;
    logic [63:0]        ea_p0;

    logic        we_p1;
    logic [2:0]  f3_p1;
    logic [63:0] ea_p1;
    logic [63:0] wdata_p1;
    logic [4:0]  rd_p1;

    logic [3:0]        size_p1;
    logic [ADDR_W:0]   last_byte_p1;
    logic              illegal_p1;
    logic              misal_p1;
    logic              fault_p1;
    logic [1:0]        exc_p1;

    function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] f3);
        logic sx;
        sx = ~f3[2];
        case (f3[1:0])
            2'b00:   return {{56{sx & raw[7]}},  raw[7:0]};
            2'b01:   return {{48{sx & raw[15]}}, raw[15:0]};
            2'b10:   return {{32{sx & raw[31]}}, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    // ---- p0: request accept, effective address
    assign imm_sx_p0 = 64'(signed'(req_imm));
    assign ea_p0     = req_base + imm_sx_p0;

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_p1    <= req_we;
            f3_p1    <= req_funct3;
            ea_p1    <= ea_p0;
            wdata_p1 <= req_wdata;
            rd_p1    <= req_rd;
        end
    end

    // ---- p1: classification and memory access
    assign size_p1      = 4'd1 << f3_p1[1:0];
    assign last_byte_p1 = {1'b0, ea_p1[ADDR_W-1:0]} + (ADDR_W+1)'(size_p1) - (ADDR_W+1)'(1);
    assign illegal_p1   = we_p1 ? f3_p1[2] : (&f3_p1);
    assign fault_p1     = (|ea_p1[63:ADDR_W]) | last_byte_p1[ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] align_mask_p1;
    assign align_mask_p1 = 3'(size_p1 - 4'd1);
    assign misal_p1      = |(ea_p1[2:0] & align_mask_p1);
`else
    assign misal_p1 = 1'b0;
`endif

    always_comb begin
        exc_p1 = 2'b00;
        if (illegal_p1)    exc_p1 = 2'b11;
        else if (misal_p1) exc_p1 = 2'b01;
        else if (fault_p1) exc_p1 = 2'b10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Memory port is driven only while a legal access is in flight, so reset clears it at once.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_addr  = '0;
        mem_dataw = '0;
        mem_word  = 2'b00;
        mem_rw    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = RESP;
                if (exc_p1 == 2'b00) begin
                    mem_addr  = ea_p1[ADDR_W-1:0];
                    mem_dataw = wdata_p1;
                    mem_word  = f3_p1[1:0];
                    mem_rw    = we_p1;
                end
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- p2: response hold
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data    <= '0;
            resp_rd      <= '0;
            resp_exc     <= 2'b00;
            resp_badaddr <= '0;
        end else if (state == ACCESS) begin
            resp_rd  <= rd_p1;
            resp_exc <= exc_p1;
            if (exc_p1 != 2'b00) begin
                resp_data    <= '0;
                resp_badaddr <= ea_p1;
            end else begin
                resp_data    <= we_p1 ? 64'd0 : load_ext(mem_datar, f3_p1);
                resp_badaddr <= '0;
            end
        end
    end

endmodule
